// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  // Execute-operand source: M beats W, $0 is hard-wired and never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] src,
                                        input logic             rw_m,
                                        input logic [REG_W-1:0] wr_m,
                                        input logic             rw_w,
                                        input logic [REG_W-1:0] wr_w);
    if (src == REG_ZERO)         return FWD_RF;
    if (rw_m && (wr_m == src))   return FWD_M;
    if (rw_w && (wr_w == src))   return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational forwarding selects for the execute ALU and decode comparator.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output fwd_sel_t         fwd_ae,
  output fwd_sel_t         fwd_be,
  output logic             fwd_ad,
  output logic             fwd_bd
);

  // Operand selects; decode only ever forwards from M.
  always_comb begin
    fwd_ae = fwd_pick(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    fwd_be = fwd_pick(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    fwd_ad = RegWriteM && (WriteRegM == RsD) && (RsD != REG_ZERO);
    fwd_bd = RegWriteM && (WriteRegM == RtD) && (RtD != REG_ZERO);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: stall/flush priority, memory-wait FSM with timeout trap,
// saturating stall-cycle counters. Forwarding lives in pipe_fwd_unit.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int               WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              lwstall, brstall, memstall;
  logic              win_mem, win_hz;
  fwd_sel_t          fwd_ae, fwd_be;
  logic              fwd_ad, fwd_bd;

  pipe_fwd_unit u_fwd (
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_ae    (fwd_ae),
    .fwd_be    (fwd_be),
    .fwd_ad    (fwd_ad),
    .fwd_bd    (fwd_bd)
  );

  // Raw hazard conditions and which one owns this cycle (ERR owns everything).
  always_comb begin
    lwstall  = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    brstall  = BranchD &&
               ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    memstall = (MemtoRegM || MemWriteM) && !mem_ready;
    win_mem  = (state != ERR) && memstall;
    win_hz   = (state != ERR) && !memstall && (lwstall || brstall);
  end

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Memory-wait sequencing; release happens in the cycle memstall drops.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: if (memstall) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = '0;
      end
      MEM_WAIT: begin
        if (!memstall) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ERR;
          wait_nxt  = '0;
        end else begin
          wait_nxt  = wait_cnt + WAIT_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Saturating performance counters, frozen once trapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (win_hz && !(&stall_cnt))    stall_cnt   <= stall_cnt + CNT_W'(1);
      if (win_mem && !(&memwait_cnt)) memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end

  // Stall/flush priority; reset forces a full freeze-and-clear.
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
    if (!rst_n) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushD = 1'b1; FlushE = 1'b1; FlushW = 1'b1;
    end else if (state == ERR || memstall) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwstall || brstall) begin
      // taken branch is re-resolved after the stall, so D is not flushed
      StallF = 1'b1; StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcD) begin
      FlushD = 1'b1;
    end
  end

  assign ForwardAE   = rst_n ? fwd_ae : FWD_RF;
  assign ForwardBE   = rst_n ? fwd_be : FWD_RF;
  assign ForwardAD   = rst_n && fwd_ad;
  assign ForwardBD   = rst_n && fwd_bd;
  assign mem_timeout = (state == ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and narrow counters.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic BranchD, PCSrcD, mem_ready;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, mem_timeout;
  logic [CW-1:0] stall_cnt, memwait_cnt;
  logic [6:0] ctl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; PCSrcD = 0; mem_ready = 1;
  endtask

  // advance one edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    RegWriteM = 1; WriteRegM = 8; RsE = 8;
    #3;
    chk("rst_ctl", 32'(ctl), 32'h7F);
    chk("rst_fwdAE", 32'(ForwardAE), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    #9 rst_n = 1'b1;
    clr_in();
    tick();

    // forwarding
    RegWriteM = 1; WriteRegM = 8; RsE = 8; #1;
    chk("fwdAE_M", 32'(ForwardAE), 2);
    chk("ctl_idle", 32'(ctl), 0);
    RegWriteW = 1; WriteRegW = 8; #1;
    chk("fwdAE_MW", 32'(ForwardAE), 2);
    RegWriteM = 0; RtE = 8; #1;
    chk("fwdAE_W", 32'(ForwardAE), 1);
    chk("fwdBE_W", 32'(ForwardBE), 1);
    RegWriteM = 1; WriteRegM = 0; RegWriteW = 1; WriteRegW = 0; RsE = 0; RtE = 0; RsD = 0; #1;
    chk("fwdAE_r0", 32'(ForwardAE), 0);
    chk("fwdAD_r0", 32'(ForwardAD), 0);

    // load-use stall
    clr_in(); tick();
    MemtoRegE = 1; RtE = 9; RsD = 9; RtD = 3; #1;
    chk("lw_ctl", 32'(ctl), 32'b1100010);
    chk("lw_cnt0", 32'(stall_cnt), 0);
    tick();
    clr_in(); #1;
    chk("lw_after", 32'(ctl), 0);
    chk("lw_cnt1", 32'(stall_cnt), 1);

    // branch hazard, then decode forward and taken-branch flush
    BranchD = 1; PCSrcD = 1; RsD = 5; RtD = 6; RegWriteE = 1; WriteRegE = 5; #1;
    chk("br_ctl", 32'(ctl), 32'b1100010);
    tick();
    chk("br_cnt", 32'(stall_cnt), 2);
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 5; #1;
    chk("br_fwdAD", 32'(ForwardAD), 1);
    chk("br_fwdBD", 32'(ForwardBD), 0);
    chk("br_flushD", 32'(ctl), 32'b0000100);
    tick();
    chk("br_cnt_hold", 32'(stall_cnt), 2);

    // memory wait of 3 cycles with a load-use hazard masked underneath
    clr_in();
    MemtoRegM = 1; mem_ready = 0; MemtoRegE = 1; RtE = 4; RsD = 4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), 32'(ctl), 32'b1111001);
      tick();
    end
    mem_ready = 1; MemtoRegE = 0; #1;
    chk("mw_rel_ctl", 32'(ctl), 0);
    chk("mw_cnt", 32'(memwait_cnt), 3);
    chk("mw_stall_mask", 32'(stall_cnt), 2);
    tick();
    chk("mw_run", 32'(dut.state), 32'(RUN));
    chk("mw_cnt_hold", 32'(memwait_cnt), 3);

    // async reset in the middle of MEM_WAIT
    clr_in(); MemtoRegM = 1; mem_ready = 0;
    tick(); tick();
    chk("ar_state", 32'(dut.state), 32'(MEM_WAIT));
    chk("ar_cnt_pre", 32'(memwait_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctl", 32'(ctl), 32'h7F);
    chk("ar_cnt", 32'(memwait_cnt), 0);
    clr_in();
    #1 rst_n = 1'b1;
    tick();
    chk("ar_run", 32'(dut.state), 32'(RUN));
    chk("ar_scnt", 32'(stall_cnt), 0);

    // stall counter saturation
    MemtoRegE = 1; RtE = 7; RtD = 7;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt", 32'(stall_cnt), 15);
    clr_in(); #1;

    // timeout trap
    MemtoRegM = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) tick();
    chk("to_pre_state", 32'(dut.state), 32'(MEM_WAIT));
    chk("to_pre_flag", 32'(mem_timeout), 0);
    tick();
    chk("to_flag", 32'(mem_timeout), 1);
    chk("to_cnt", 32'(memwait_cnt), TO + 1);
    mem_ready = 1; MemtoRegM = 0; #1;
    chk("to_ctl", 32'(ctl), 32'b1111001);
    tick(); tick();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_cnt_hold", 32'(memwait_cnt), TO + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("to_rst_flag", 32'(mem_timeout), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("to_rst_ctl", 32'(ctl), 0);
    chk("to_rst_cnt", 32'(memwait_cnt), 0);
    chk("to_rst_state", 32'(dut.state), 32'(RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
